// File: rtl/cic_pkg.sv
// Shared defaults, FSM encoding and output-window helper for the time-shared CIC comb.
// Build option CIC_COMB_SAT_EN: saturate the output window instead of wrapping.
package cic_pkg;

  localparam int CIC_DW = 37;
  localparam int CIC_OW = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // c is the sign-extended comb result; the caller keeps the low ow bits of the return value.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] c,
                                                   input int ow, input int osh);
    logic signed [63:0] w;
    logic signed [63:0] lim;
    w   = c >>> osh;
    lim = 64'sd1 <<< (ow - 1);
`ifdef CIC_COMB_SAT_EN
    if (w >= lim) w = lim - 64'sd1;
    else if (w < -lim) w = -lim;
`else
    w = w & ((lim <<< 1) - 64'sd1);
`endif
    return w;
  endfunction

endpackage

// File: rtl/cic_rr_arb.sv
// Round-robin priority picker: first set request at or after i_ptr, searching upward with wrap at NCH-1.
module cic_rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [CW-1:0]  o_idx,
  output logic           o_any
);

  always_comb begin
    logic [CW:0] w_pos;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pos = {1'b0, i_ptr} + (CW+1)'(i);
      if (w_pos >= (CW+1)'(NCH)) w_pos = w_pos - (CW+1)'(NCH);
      if (!o_any && i_req[w_pos[CW-1:0]]) begin
        o_any                = 1'b1;
        o_gnt[w_pos[CW-1:0]] = 1'b1;
        o_idx                = w_pos[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/cic_comb_sched.sv
// Time-shared 3-stage CIC comb serving NCH channels round-robin through one subtractor chain.
// IDLE->CALC->OUT, at least 3 cycles per sample; CIC_COMB_SAT_EN saturates the output window.
module cic_comb_sched
  import cic_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int DW  = CIC_DW,
  parameter  int OW  = CIC_OW,
  parameter  int OSH = 0,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*DW-1:0]    din,
  output logic [NCH-1:0]       gnt,
  output logic signed [OW-1:0] dout,
  output logic [CW-1:0]        dout_ch,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 busy
);

  state_t r_state, w_next;

  logic [CW-1:0]        r_ptr, r_chr, r_dout_ch;
  logic signed [DW-1:0] r_xr;
  logic signed [DW-1:0] r_s1 [NCH];
  logic signed [DW-1:0] r_s2 [NCH];
  logic signed [DW-1:0] r_s3 [NCH];
  logic [NCH-1:0]       r_gnt;
  logic signed [OW-1:0] r_dout;
  logic                 r_dout_vld;

  logic [NCH-1:0]       w_arb_gnt;
  logic [CW-1:0]        w_arb_idx;
  logic                 w_arb_any;
  logic                 w_take, w_calc, w_ack;
  logic signed [DW-1:0] w_din_sel, w_c1, w_c2, w_c3;

  cic_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_next = CALC;
      CALC:    w_next = OUT;
      OUT:     if (dout_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_take = (r_state == IDLE) && w_arb_any;
    w_calc = (r_state == CALC);
    w_ack  = (r_state == OUT) && dout_rdy;
    busy   = (r_state != IDLE);
  end

  assign w_din_sel = din[int'(w_arb_idx)*DW +: DW];
  // All three differences wrap mod 2^DW, matching the integrators upstream.
  assign w_c1 = r_xr - r_s1[r_chr];
  assign w_c2 = w_c1 - r_s2[r_chr];
  assign w_c3 = w_c2 - r_s3[r_chr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_chr      <= '0;
      r_xr       <= '0;
      r_gnt      <= '0;
      r_dout     <= '0;
      r_dout_ch  <= '0;
      r_dout_vld <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_s1[i] <= '0;
        r_s2[i] <= '0;
        r_s3[i] <= '0;
      end
    end else begin
      r_gnt <= '0;
      if (w_take) begin
        r_xr  <= w_din_sel;
        r_chr <= w_arb_idx;
        r_gnt <= w_arb_gnt;
        r_ptr <= (w_arb_idx == CW'(NCH-1)) ? '0 : w_arb_idx + 1'b1;
      end
      if (w_calc) begin
        r_s1[r_chr] <= r_xr;
        r_s2[r_chr] <= w_c1;
        r_s3[r_chr] <= w_c2;
        r_dout      <= OW'(sat_trunc(64'(w_c3), OW, OSH));
        r_dout_ch   <= r_chr;
        r_dout_vld  <= 1'b1;
      end
      if (w_ack) r_dout_vld <= 1'b0;
    end
  end

  assign gnt      = r_gnt;
  assign dout     = r_dout;
  assign dout_ch  = r_dout_ch;
  assign dout_vld = r_dout_vld;

endmodule
